// File: rtl/pwm_pkg.sv
// pwm_pkg: config address map and mode/direction encodings shared by the PWM controller
package pwm_pkg;
  localparam int ADDR_PERIOD = 0;
  localparam int ADDR_PRESC = 1;
  localparam int ADDR_DUTY0 = 2;
  typedef enum logic {MODE_EDGE = 1'b0, MODE_CENTER = 1'b1} mode_e;
  typedef enum logic {DIR_UP = 1'b0, DIR_DOWN = 1'b1} dir_e;
endpackage

// File: rtl/pwm_timebase.sv
// pwm_timebase: prescaled up or up/down counter with a period_complete pulse on return to 0
module pwm_timebase import pwm_pkg::*; #(
  parameter int CNT_W = 16,
  parameter int PRESC_W = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               enable,
  input  logic               restart,
  input  mode_e              mode,
  input  logic [CNT_W-1:0]   period,
  input  logic [PRESC_W-1:0] presc,
  output logic [CNT_W-1:0]   count,
  output logic               period_complete
);
  logic [PRESC_W-1:0] presc_cnt_q, presc_cnt_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  dir_e dir_q, dir_d;
  logic pc_q, pc_d, tick;
  // >= rather than == so a smaller prescaler loaded mid-count cannot stall for a full wrap
  assign tick = enable & (presc_cnt_q >= presc);
  always_comb begin
    presc_cnt_d = presc_cnt_q;
    cnt_d = cnt_q;
    dir_d = dir_q;
    pc_d = 1'b0;
    if (enable) presc_cnt_d = tick ? '0 : presc_cnt_q + 1'b1;
    if (tick) begin
      if (period == '0 || (mode == MODE_EDGE && cnt_q >= period)) begin
        cnt_d = '0;
        dir_d = DIR_UP;
        pc_d = 1'b1;
      end else if (mode == MODE_EDGE || dir_q == DIR_UP) begin
        cnt_d = cnt_q + 1'b1;
        dir_d = (mode == MODE_CENTER && cnt_q == period - 1'b1) ? DIR_DOWN : DIR_UP;
      end else begin
        cnt_d = cnt_q - 1'b1;
        dir_d = (cnt_q == CNT_W'(1)) ? DIR_UP : DIR_DOWN;
        pc_d = cnt_q == CNT_W'(1);
      end
    end
    if (restart) begin
      cnt_d = '0;
      dir_d = DIR_UP;
      presc_cnt_d = '0;
      pc_d = 1'b0;
    end
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      presc_cnt_q <= '0;
      cnt_q <= '0;
      dir_q <= DIR_UP;
      pc_q <= 1'b0;
    end else begin
      presc_cnt_q <= presc_cnt_d;
      cnt_q <= cnt_d;
      dir_q <= dir_d;
      pc_q <= pc_d;
    end
  assign count = cnt_q;
  assign period_complete = pc_q;
endmodule

// File: rtl/pwm_multichannel_ctrl.sv
// pwm_multichannel_ctrl: N-channel PWM with shadow-buffered config committed at period boundaries
module pwm_multichannel_ctrl import pwm_pkg::*; #(
  parameter int NUM_CH = 4,
  parameter int CNT_W = 16,
  parameter int PRESC_W = 8,
  parameter int ADDR_W = $clog2(NUM_CH + 2)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              timer_enable,
  input  logic              center_mode,
  input  logic [NUM_CH-1:0] ch_enable,
  input  logic [NUM_CH-1:0] ch_polarity,
  input  logic              cfg_we,
  input  logic [ADDR_W-1:0] cfg_addr,
  input  logic [CNT_W-1:0]  cfg_wdata,
  input  logic              cfg_commit,
  output logic              cfg_busy,
  output logic              update_done,
  output logic [NUM_CH-1:0] pwm_out,
  output logic              period_complete,
  output logic [CNT_W-1:0]  counter_val
);
  logic [CNT_W-1:0] period_q, period_d, period_sh_q, period_sh_d;
  logic [PRESC_W-1:0] presc_q, presc_d, presc_sh_q, presc_sh_d;
  logic [NUM_CH-1:0][CNT_W-1:0] duty_q, duty_d, duty_sh_q, duty_sh_d;
  mode_e mode_q, mode_d, new_mode;
  logic pending_q, pending_d;
  logic [NUM_CH-1:0] pwm_q, pwm_d, raw;
  logic load, restart;
  assign new_mode = mode_e'(center_mode);
  assign load = pending_q & (~timer_enable | period_complete);
  assign restart = load & (new_mode != mode_q || period_sh_q != period_q);
  pwm_timebase #(.CNT_W(CNT_W), .PRESC_W(PRESC_W)) u_tb (
    .clk(clk),
    .reset(reset),
    .enable(timer_enable),
    .restart(restart),
    .mode(mode_q),
    .period(period_q),
    .presc(presc_q),
    .count(counter_val),
    .period_complete(period_complete)
  );
  for (genvar k = 0; k < NUM_CH; k++) begin : g_cmp
    assign raw[k] = counter_val < duty_q[k];
  end
  // active registers copy the shadow as it stood before any same-cycle write
  always_comb begin
    period_sh_d = period_sh_q;
    presc_sh_d = presc_sh_q;
    duty_sh_d = duty_sh_q;
    if (cfg_we && cfg_addr == ADDR_W'(ADDR_PERIOD)) period_sh_d = cfg_wdata;
    if (cfg_we && cfg_addr == ADDR_W'(ADDR_PRESC)) presc_sh_d = cfg_wdata[PRESC_W-1:0];
    for (int i = 0; i < NUM_CH; i++)
      if (cfg_we && cfg_addr == ADDR_W'(ADDR_DUTY0 + i)) duty_sh_d[i] = cfg_wdata;
    period_d = load ? period_sh_q : period_q;
    presc_d = load ? presc_sh_q : presc_q;
    duty_d = load ? duty_sh_q : duty_q;
    mode_d = load ? new_mode : mode_q;
    pending_d = ~load & (pending_q | cfg_commit);
    for (int i = 0; i < NUM_CH; i++)
      pwm_d[i] = ch_enable[i] ? raw[i] ^ ch_polarity[i] : ch_polarity[i];
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      period_q <= '1;
      period_sh_q <= '1;
      presc_q <= '0;
      presc_sh_q <= '0;
      duty_q <= '0;
      duty_sh_q <= '0;
      mode_q <= MODE_EDGE;
      pending_q <= 1'b0;
      pwm_q <= '0;
    end else begin
      period_q <= period_d;
      period_sh_q <= period_sh_d;
      presc_q <= presc_d;
      presc_sh_q <= presc_sh_d;
      duty_q <= duty_d;
      duty_sh_q <= duty_sh_d;
      mode_q <= mode_d;
      pending_q <= pending_d;
      pwm_q <= pwm_d;
    end
  assign cfg_busy = pending_q;
  assign update_done = load;
  assign pwm_out = pwm_q;
endmodule
